// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Write-side front end for the register file. Results from the execute and
// memory units are buffered in a small circular queue and drained one per
// clock into an output stage. The output stage drives the register file's
// pos/writevalue directly, and parks on register 0 with data 0 when idle.
// A pending mask covers every queued or presented write so that hazard
// logic can stall readers of those registers.
//
// Optional build macro: WBQ_FORWARD_EN
//   When defined, two lookup ports are added. Each one returns the youngest
//   queued or presented value for its register index.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_rd,
  input  logic [DATA_W-1:0]       in_value,
`ifdef WBQ_FORWARD_EN
  input  logic [4:0]              lk_pos1,
  input  logic [4:0]              lk_pos2,
  output logic                    lk_hit1,
  output logic                    lk_hit2,
  output logic [DATA_W-1:0]       lk_value1,
  output logic [DATA_W-1:0]       lk_value2,
`endif
  output logic [4:0]              pos,
  output logic [DATA_W-1:0]       writevalue,
  output logic [31:0]             pending,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        rd_mem_q  [DEPTH];
  logic [4:0]        rd_mem_d  [DEPTH];
  logic [DATA_W-1:0] val_mem_q [DEPTH];
  logic [DATA_W-1:0] val_mem_d [DEPTH];
  logic [4:0]        out_pos_q, out_pos_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic              out_vld_q, out_vld_d;

  logic              push;
  logic              pop;
  logic              entry_vld [DEPTH];
  logic [AW-1:0]     entry_off;

  // Ready looks only at registered occupancy, never at the same-edge pop
  always_comb begin
    in_ready = !reset && (count_q < DEPTH_C);
    // Writes to register 0 are accepted but never occupy a slot
    push     = in_valid && in_ready && (in_rd != 5'd0);
    pop      = (count_q != '0);
  end

  // Next-state for queue storage, pointers, occupancy and the output stage
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_mem_d  = rd_mem_q;
    val_mem_d = val_mem_q;
    out_pos_d = 5'd0;
    out_val_d = '0;
    out_vld_d = 1'b0;
    if (push) begin
      rd_mem_d[wr_ptr_q]  = in_rd;
      val_mem_d[wr_ptr_q] = in_value;
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      out_pos_d = rd_mem_q[rd_ptr_q];
      out_val_d = val_mem_q[rd_ptr_q];
      out_vld_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and output stage, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_pos_q <= 5'd0;
      out_val_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_pos_q <= out_pos_d;
      out_val_q <= out_val_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Queue payload needs no reset: slots are only read while marked valid
  always_ff @(posedge clock) begin
    rd_mem_q  <= rd_mem_d;
    val_mem_q <= val_mem_d;
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    entry_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_off    = AW'(i) - rd_ptr_q;
      entry_vld[i] = ({1'b0, entry_off} < count_q);
    end
  end

  // Pending mask over live slots plus the presented write; r0 never stalls
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pending[rd_mem_q[i]] = 1'b1;
    end
    if (out_vld_q) pending[out_pos_q] = 1'b1;
    pending[0] = 1'b0;
  end

`ifdef WBQ_FORWARD_EN
  logic [AW-1:0] lk_idx;

  // Scan oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    lk_hit1   = 1'b0;
    lk_hit2   = 1'b0;
    lk_value1 = '0;
    lk_value2 = '0;
    lk_idx    = '0;
    if (out_vld_q && (out_pos_q == lk_pos1)) begin
      lk_hit1   = 1'b1;
      lk_value1 = out_val_q;
    end
    if (out_vld_q && (out_pos_q == lk_pos2)) begin
      lk_hit2   = 1'b1;
      lk_value2 = out_val_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr_q + AW'(k);
      if ((CW'(k) < count_q) && (rd_mem_q[lk_idx] == lk_pos1)) begin
        lk_hit1   = 1'b1;
        lk_value1 = val_mem_q[lk_idx];
      end
      if ((CW'(k) < count_q) && (rd_mem_q[lk_idx] == lk_pos2)) begin
        lk_hit2   = 1'b1;
        lk_value2 = val_mem_q[lk_idx];
      end
    end
    if (lk_pos1 == 5'd0) begin
      lk_hit1   = 1'b0;
      lk_value1 = '0;
    end
    if (lk_pos2 == 5'd0) begin
      lk_hit2   = 1'b0;
      lk_value2 = '0;
    end
  end
`endif

  // Output stage drives the register-file write port directly
  always_comb begin
    pos        = out_pos_q;
    writevalue = out_val_q;
    q_count    = count_q;
  end

endmodule
